memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter: TIMEOUT, 16, max cycles the block waits for i_dmem_ack before aborting an access (range 2..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 i_register_file_wr_addr_E  in  5  destination register from execute.
REQ-005 i_ALU_output_E  in  32  ALU result; used as the memory byte address.
REQ-006 i_wr_data_E  in  32  store data.
REQ-007 i_register_file_wr_en_E / i_data_memory_wr_en_E / i_sel_result_E  in  1 each  register write enable, store enable, load select (1 = result from memory).
REQ-008 o_dmem_req / o_dmem_we  out  1 each  memory request, write strobe.
REQ-009 o_dmem_addr / o_dmem_wdata  out  32 each  memory address, store data.
REQ-010 i_dmem_ack  in  1; i_dmem_rdata  in  32  memory completion and load data.
REQ-011 o_ALU_output_M  out  32; o_register_file_wr_addr_M  out  5; o_register_file_wr_en_M  out  1  M-stage values for forwarding and hazard detection.
REQ-012 o_result_W  out  32; o_register_file_wr_addr_W  out  5; o_register_file_wr_en_W  out  1  writeback register.
REQ-013 o_stall_M  out  1  hold the upstream pipeline.
REQ-014 o_dmem_timeout  out  1  sticky timeout error flag.

Function
REQ-015 The M register shall capture all E inputs on each clk edge where o_stall_M=0, and shall hold its contents while o_stall_M=1.
REQ-016 mem_op = M-stage load (sel_result) or store (data_memory_wr_en); a non-memory op shall pass to W in one cycle with o_result_W = ALU output.
REQ-017 FSM states IDLE, WAIT; IDLE->WAIT when mem_op and no ack; WAIT->IDLE on ack or on timeout; IDLE stays IDLE when ack arrives the same cycle.
REQ-018 o_dmem_req shall equal mem_op while in IDLE or WAIT and not aborted; o_dmem_we = M store bit; addr/wdata driven directly from the M register.
REQ-019 o_stall_M = mem_op & ~i_dmem_ack & ~timeout_hit; a zero-wait memory shall give no stall.
REQ-020 On the ack cycle, W shall capture i_dmem_rdata for loads or the ALU output for stores, with the M wr_addr and wr_en.
REQ-021 While o_stall_M=1, W shall capture a bubble with o_register_file_wr_en_W=0.
REQ-022 The wait counter shall clear on entering WAIT and increment each WAIT cycle; at count TIMEOUT-1 without ack, timeout_hit shall abort the access, release the stall, set o_dmem_timeout, and retire the instruction with wr_en_W=0.
REQ-023 o_dmem_timeout shall remain 1 until rst.
REQ-024 i_dmem_ack shall be ignored when o_dmem_req=0.
REQ-025 An ack and a timeout in the same cycle: the ack shall win with a normal retire and no error.

Reset
REQ-026 rst shall asynchronously force FSM=IDLE, counter=0, and all M and W registers to 0, giving all outputs 0 including o_dmem_req, o_stall_M and o_dmem_timeout.
REQ-027 rst asserted during WAIT shall drop o_dmem_req immediately and discard the access.

Structure
REQ-028 The state enum (IDLE, WAIT) and the TIMEOUT default shall live in shared package riscv_pkg.
REQ-029 No sub-module; FSM, counter and pipeline registers shall be inline.

Verification
REQ-030 Test: add x5 with ALU=0x0000_0010 and no mem_op -> next cycle o_result_W=0x10, addr_W=5, wr_en_W=1, stall never 1.
REQ-031 Test: load addr 0x100 with ack in the same cycle and rdata=0xDEADBEEF -> req for 1 cycle, no stall, o_result_W=0xDEADBEEF.
REQ-032 Test: store addr 0x200, wdata 0x1234, ack after 3 cycles -> stall=1 for 3 cycles, we=1, 3 W bubbles, then retire with wr_en_W=0.
REQ-033 Test: load with no ack and TIMEOUT=16 -> stall for 16 cycles, then o_dmem_timeout=1 sticky, wr_en_W=0, pipeline resumes.
REQ-034 Test: rst pulse mid-WAIT -> o_dmem_req=0 asynchronously, all outputs 0, and a later load completes normally.
REQ-035 Test: ack exactly at count TIMEOUT-1 -> normal retire and o_dmem_timeout stays 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the memory-access pipeline stage.
package riscv_pkg;

    // Default number of cycles to wait for a data-memory acknowledge.
    localparam int TIMEOUT_DEFAULT = 16;

    // Memory handshake FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/memory_access.sv
// M pipeline stage: holds the execute result, runs the data-memory handshake
// with a bounded wait, and feeds the writeback register.
//
// Memory handshake: o_dmem_req is held high for as long as the M-stage op is a
// load or store; the memory completes it by raising i_dmem_ack for exactly one
// cycle while o_dmem_req is high. An ack seen while o_dmem_req is low is
// ignored. If no ack arrives by wait count TIMEOUT-1 the access is abandoned.
module memory_access
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_register_file_wr_addr_E,
    input  logic [31:0] i_ALU_output_E,
    input  logic [31:0] i_wr_data_E,
    input  logic        i_register_file_wr_en_E,
    input  logic        i_data_memory_wr_en_E,
    input  logic        i_sel_result_E,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic [31:0] o_ALU_output_M,
    output logic [4:0]  o_register_file_wr_addr_M,
    output logic        o_register_file_wr_en_M,
    output logic [31:0] o_result_W,
    output logic [4:0]  o_register_file_wr_addr_W,
    output logic        o_register_file_wr_en_W,
    output logic        o_stall_M,
    output logic        o_dmem_timeout
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    // M-stage register contents
    logic [4:0]  m_wr_addr;
    logic [31:0] m_alu;
    logic [31:0] m_wdata;
    logic        m_rf_we;
    logic        m_dm_we;
    logic        m_sel_result;

    mem_state_t  state;
    mem_state_t  state_next;
    logic [7:0]  wait_cnt;

    logic        mem_op;
    logic        ack_valid;
    logic        timeout_hit;

    assign mem_op      = m_sel_result | m_dm_we;
    assign o_dmem_req  = mem_op;
    assign ack_valid   = i_dmem_ack & o_dmem_req;
    // Ack on the last allowed cycle takes priority over the abort.
    assign timeout_hit = (state == WAIT) && (wait_cnt == LAST_COUNT) && !ack_valid;
    assign o_stall_M   = mem_op & ~ack_valid & ~timeout_hit;

    assign o_dmem_we    = m_dm_we;
    assign o_dmem_addr  = m_alu;
    assign o_dmem_wdata = m_wdata;

    assign o_ALU_output_M            = m_alu;
    assign o_register_file_wr_addr_M = m_wr_addr;
    assign o_register_file_wr_en_M   = m_rf_we;

    // M register: capture execute outputs unless the stage is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wr_addr    <= '0;
            m_alu        <= '0;
            m_wdata      <= '0;
            m_rf_we      <= 1'b0;
            m_dm_we      <= 1'b0;
            m_sel_result <= 1'b0;
        end else if (!o_stall_M) begin
            m_wr_addr    <= i_register_file_wr_addr_E;
            m_alu        <= i_ALU_output_E;
            m_wdata      <= i_wr_data_E;
            m_rf_we      <= i_register_file_wr_en_E;
            m_dm_we      <= i_data_memory_wr_en_E;
            m_sel_result <= i_sel_result_E;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: wait only when the access did not complete immediately.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (mem_op && !ack_valid) state_next = WAIT;
            WAIT: if (ack_valid || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Wait counter: zero while idle so it starts at 0 on entering WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_dmem_timeout <= 1'b0;
        end else if (timeout_hit) begin
            o_dmem_timeout <= 1'b1;
        end
    end

    // W register: bubble while stalled, aborted ops retire without writing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_result_W                <= '0;
            o_register_file_wr_addr_W <= '0;
            o_register_file_wr_en_W   <= 1'b0;
        end else if (o_stall_M) begin
            o_result_W                <= '0;
            o_register_file_wr_addr_W <= '0;
            o_register_file_wr_en_W   <= 1'b0;
        end else begin
            o_result_W                <= (m_sel_result && ack_valid) ? i_dmem_rdata : m_alu;
            o_register_file_wr_addr_W <= m_wr_addr;
            o_register_file_wr_en_W   <= m_rf_we & ~timeout_hit;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the memory-access stage.
module tb_memory_access;

    logic        clk;
    logic        rst;
    logic [4:0]  wr_addr_e;
    logic [31:0] alu_e;
    logic [31:0] wr_data_e;
    logic        rf_we_e;
    logic        dm_we_e;
    logic        sel_e;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] alu_m;
    logic [4:0]  wr_addr_m;
    logic        wr_en_m;
    logic [31:0] result_w;
    logic [4:0]  wr_addr_w;
    logic        wr_en_w;
    logic        stall_m;
    logic        dmem_timeout;

    int tests_run = 0;
    int tests_failed = 0;

    memory_access #(.TIMEOUT(16)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .i_register_file_wr_addr_E (wr_addr_e),
        .i_ALU_output_E            (alu_e),
        .i_wr_data_E               (wr_data_e),
        .i_register_file_wr_en_E   (rf_we_e),
        .i_data_memory_wr_en_E     (dm_we_e),
        .i_sel_result_E            (sel_e),
        .o_dmem_req                (dmem_req),
        .o_dmem_we                 (dmem_we),
        .o_dmem_addr               (dmem_addr),
        .o_dmem_wdata              (dmem_wdata),
        .i_dmem_ack                (dmem_ack),
        .i_dmem_rdata              (dmem_rdata),
        .o_ALU_output_M            (alu_m),
        .o_register_file_wr_addr_M (wr_addr_m),
        .o_register_file_wr_en_M   (wr_en_m),
        .o_result_W                (result_w),
        .o_register_file_wr_addr_W (wr_addr_w),
        .o_register_file_wr_en_W   (wr_en_w),
        .o_stall_M                 (stall_m),
        .o_dmem_timeout            (dmem_timeout)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic [4:0] a, input logic [31:0] alu, input logic [31:0] wd,
                           input logic rf, input logic dm, input logic sel);
        wr_addr_e = a;
        alu_e     = alu;
        wr_data_e = wd;
        rf_we_e   = rf;
        dm_we_e   = dm;
        sel_e     = sel;
    endtask

    task automatic drive_nop();
        drive_e(5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive_nop();
        #1;
        // Reset state
        check("rst_req", {31'b0, dmem_req}, 32'h0);
        check("rst_stall", {31'b0, stall_m}, 32'h0);
        check("rst_timeout", {31'b0, dmem_timeout}, 32'h0);
        check("rst_result_w", result_w, 32'h0);
        check("rst_wr_en_w", {31'b0, wr_en_w}, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Non-memory add x5 = 0x10
        drive_e(5'd5, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
        dmem_ack = 1'b1;   // ack with no request must be ignored
        tick();
        dmem_ack = 1'b0;
        drive_nop();
        check("add_alu_m", alu_m, 32'h10);
        check("add_addr_m", {27'b0, wr_addr_m}, 32'd5);
        check("add_stall", {31'b0, stall_m}, 32'h0);
        check("add_req", {31'b0, dmem_req}, 32'h0);
        tick();
        check("add_result_w", result_w, 32'h10);
        check("add_addr_w", {27'b0, wr_addr_w}, 32'd5);
        check("add_wr_en_w", {31'b0, wr_en_w}, 32'h1);

        // Zero-wait load
        drive_e(5'd7, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        drive_nop();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        check("ld0_req", {31'b0, dmem_req}, 32'h1);
        check("ld0_we", {31'b0, dmem_we}, 32'h0);
        check("ld0_addr", dmem_addr, 32'h100);
        check("ld0_stall", {31'b0, stall_m}, 32'h0);
        tick();
        dmem_ack = 1'b0;
        check("ld0_result_w", result_w, 32'hDEADBEEF);
        check("ld0_addr_w", {27'b0, wr_addr_w}, 32'd7);
        check("ld0_wr_en_w", {31'b0, wr_en_w}, 32'h1);
        check("ld0_req_after", {31'b0, dmem_req}, 32'h0);

        // Store with ack after three stalled cycles
        drive_e(5'd0, 32'h200, 32'h1234, 1'b0, 1'b1, 1'b0);
        tick();
        drive_nop();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("st_stall_%0d", i), {31'b0, stall_m}, 32'h1);
            check($sformatf("st_we_%0d", i), {31'b0, dmem_we}, 32'h1);
            check($sformatf("st_wdata_%0d", i), dmem_wdata, 32'h1234);
            check($sformatf("st_addr_%0d", i), dmem_addr, 32'h200);
            tick();
            check($sformatf("st_bubble_%0d", i), {31'b0, wr_en_w}, 32'h0);
            check($sformatf("st_bubble_res_%0d", i), result_w, 32'h0);
        end
        dmem_ack = 1'b1;
        #1;
        check("st_ack_stall", {31'b0, stall_m}, 32'h0);
        tick();
        dmem_ack = 1'b0;
        check("st_result_w", result_w, 32'h200);
        check("st_wr_en_w", {31'b0, wr_en_w}, 32'h0);
        check("st_timeout", {31'b0, dmem_timeout}, 32'h0);
        check("st_req_after", {31'b0, dmem_req}, 32'h0);

        // Load with no ack: times out after 16 stalled cycles
        drive_e(5'd9, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        drive_nop();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("to_stall_%0d", i), {31'b0, stall_m}, 32'h1);
            tick();
        end
        check("to_release", {31'b0, stall_m}, 32'h0);
        check("to_flag_pre", {31'b0, dmem_timeout}, 32'h0);
        // Next instruction enters E as the stall releases
        drive_e(5'd3, 32'h55, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        drive_nop();
        check("to_flag", {31'b0, dmem_timeout}, 32'h1);
        check("to_wr_en_w", {31'b0, wr_en_w}, 32'h0);
        check("to_addr_w", {27'b0, wr_addr_w}, 32'd9);
        check("to_req_after", {31'b0, dmem_req}, 32'h0);
        check("to_resume_m", alu_m, 32'h55);
        tick();
        check("to_resume_w", result_w, 32'h55);
        check("to_resume_en", {31'b0, wr_en_w}, 32'h1);
        tick();
        check("to_sticky", {31'b0, dmem_timeout}, 32'h1);

        // Reset pulse in the middle of a wait
        drive_e(5'd4, 32'h400, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        drive_nop();
        tick();
        check("rw_req_before", {31'b0, dmem_req}, 32'h1);
        check("rw_stall_before", {31'b0, stall_m}, 32'h1);
        rst = 1'b1;
        #1;
        check("rw_req", {31'b0, dmem_req}, 32'h0);
        check("rw_stall", {31'b0, stall_m}, 32'h0);
        check("rw_timeout", {31'b0, dmem_timeout}, 32'h0);
        check("rw_alu_m", alu_m, 32'h0);
        check("rw_dmem_addr", dmem_addr, 32'h0);
        #2;
        rst = 1'b0;
        tick();
        check("rw_result_w", result_w, 32'h0);
        drive_e(5'd6, 32'h500, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        drive_nop();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        #1;
        check("rw_ld_stall", {31'b0, stall_m}, 32'h0);
        tick();
        dmem_ack = 1'b0;
        check("rw_ld_result", result_w, 32'h0BADF00D);
        check("rw_ld_wr_en", {31'b0, wr_en_w}, 32'h1);

        // Ack on the last allowed wait cycle wins over the timeout
        drive_e(5'd11, 32'h600, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        drive_nop();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("edge_stall_%0d", i), {31'b0, stall_m}, 32'h1);
            tick();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        #1;
        check("edge_ack_stall", {31'b0, stall_m}, 32'h0);
        tick();
        dmem_ack = 1'b0;
        check("edge_result", result_w, 32'hCAFEF00D);
        check("edge_addr_w", {27'b0, wr_addr_w}, 32'd11);
        check("edge_wr_en", {31'b0, wr_en_w}, 32'h1);
        check("edge_timeout", {31'b0, dmem_timeout}, 32'h0);
        tick();
        check("edge_timeout_late", {31'b0, dmem_timeout}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
